// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store initiator between the MIPS memory stage and one port of a
//   byte-enabled dual-port data BRAM. Accepts one LB/LBU/LH/LHU/LW/SB/SH/SW
//   request at a time. It drives the BRAM word address, byte write enables and
//   lane-replicated store data in the accept cycle. It waits out the BRAM read
//   latency and returns aligned, sign- or zero-extended load data.
//   Misaligned and invalid-size requests are answered with an error and
//   never touch memory.
//
// Parameters
//   RAM_ADDR_WIDTH  BRAM word address width (default 11, depth 2048)
//   READ_LATENCY    BRAM read latency in cycles, 1 or 2
//
// Configuration macro
//   MEM_ACCESS_BIG_ENDIAN_EN  when defined, byte offset k maps to lane 3-k
//                             (big-endian); otherwise offset k maps to lane k.
//
// Ports
//   i_clock, i_reset_n      clock, asynchronous active-low reset
//   i_req_*/o_req_ready     request handshake and payload
//   o_rsp_valid/rdata/err   one-cycle response pulse with load data / error
//   o_ram_en/we/addr/data   BRAM port drive (combinational in accept cycle)
//   o_ram_rea               BRAM output register enable, high while waiting
//   i_ram_data              BRAM read data
module mem_access_unit #(
  parameter int RAM_ADDR_WIDTH = 11,
  parameter int READ_LATENCY   = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [1:0]                i_req_size,
  input  logic                      i_req_unsigned,
  input  logic [31:0]               i_req_addr,
  input  logic [31:0]               i_req_wdata,
  output logic                      o_rsp_valid,
  output logic [31:0]               o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic                      o_ram_en,
  output logic [3:0]                o_ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [31:0]               o_ram_data,
  output logic                      o_ram_rea,
  input  logic [31:0]               i_ram_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        load_q, load_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] raw_q, raw_d;

  logic        accept;
  logic        legal;
  logic [1:0]  req_off;

  // Byte write-enable pattern for a store of the given size at byte offset off.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
      SIZE_BYTE: m = 4'b1000 >> off;
      SIZE_HALF: m = 4'b1100 >> off;
`else
      SIZE_BYTE: m = 4'b0001 << off;
      SIZE_HALF: m = 4'b0011 << off;
`endif
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

  // Store data replicated across all lanes so the enables alone pick the target.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SIZE_BYTE: d = {4{wdata[7:0]}};
      SIZE_HALF: d = {2{wdata[15:0]}};
      default:   d = wdata;
    endcase
    return d;
  endfunction

  // Pull the addressed byte/half out of the BRAM word and extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [1:0]         lane_b;
    logic [1:0]         lane_h;
    logic [31:0]        sh_b;
    logic [31:0]        sh_h;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
    lane_b = 2'd3 - off;
    lane_h = 2'd2 - off;   // low-order byte of the half sits at offset off+1
`else
    lane_b = off;
    lane_h = off;
`endif
    sh_b = raw >> {lane_b, 3'b000};
    sh_h = raw >> {lane_h, 3'b000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (size)
      SIZE_BYTE: res = {{24{b[7] & ~uns}}, b};
      SIZE_HALF: res = {{16{h[15] & ~uns}}, h};
      default:   res = raw;
    endcase
    return res;
  endfunction

  assign req_off = i_req_addr[1:0];
  assign accept  = i_req_valid && (state_q == ST_IDLE);
  assign legal   = (i_req_size == SIZE_BYTE) ||
                   ((i_req_size == SIZE_HALF) && !i_req_addr[0]) ||
                   ((i_req_size == SIZE_WORD) && (req_off == 2'b00));

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // Request attributes and captured read word carry no reset; they are only
  // consumed in RESP, which is always preceded by a fresh capture.
  always_ff @(posedge i_clock) begin
    off_q  <= off_d;
    size_q <= size_d;
    uns_q  <= uns_d;
    raw_q  <= raw_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    load_d  = load_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    raw_d   = raw_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d  = !legal;
          load_d = legal && !i_req_we;
          off_d  = req_off;
          size_d = i_req_size;
          uns_d  = i_req_unsigned;
          cnt_d  = 2'(READ_LATENCY - 1);
          state_d = (legal && !i_req_we) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          // Final wait cycle: BRAM output is valid now.
          raw_d   = i_ram_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_req_ready = (state_q == ST_IDLE);
    o_ram_rea   = (state_q == ST_WAIT);
    o_rsp_valid = (state_q == ST_RESP);
    o_rsp_err   = (state_q == ST_RESP) && err_q;
    o_rsp_rdata = 32'd0;
    if ((state_q == ST_RESP) && load_q && !err_q)
      o_rsp_rdata = extend_load(raw_q, size_q, off_q, uns_q);

    // RAM port is driven only in the accept cycle of a legal request.
    o_ram_en   = 1'b0;
    o_ram_we   = 4'b0000;
    o_ram_addr = '0;
    o_ram_data = 32'd0;
    if (accept && legal) begin
      o_ram_en   = 1'b1;
      o_ram_addr = i_req_addr[RAM_ADDR_WIDTH+1:2];
      if (i_req_we) begin
        o_ram_we   = store_mask(i_req_size, req_off);
        o_ram_data = store_data(i_req_size, i_req_wdata);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int AW = 11;
  localparam int RL = 2;
  localparam int NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [1:0]    i_req_size;
  logic          i_req_unsigned;
  logic [31:0]   i_req_addr;
  logic [31:0]   i_req_wdata;
  logic          o_rsp_valid;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_ram_en;
  logic [3:0]    o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [31:0]   o_ram_data;
  logic          o_ram_rea;
  logic [31:0]   i_ram_data;

  mem_access_unit #(.RAM_ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .i_clock(clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_data(o_ram_data), .o_ram_rea(o_ram_rea), .i_ram_data(i_ram_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    bit          is_load;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t q[$];

  // Reference memory: plain byte-addressed array.
  logic [7:0] ref_mem [NBYTES];

  // BRAM model: word array with lanes, optional output register.
  logic [31:0] bram [1 << AW];
  logic [31:0] st1 = 32'd0;
  logic [31:0] st2 = 32'd0;
  always @(posedge clk) begin
    if (o_ram_en) begin
      for (int k = 0; k < 4; k++)
        if (o_ram_we[k]) bram[o_ram_addr][8*k +: 8] <= o_ram_data[8*k +: 8];
      st1 <= bram[o_ram_addr];
    end
    if (o_ram_rea) st2 <= st1;
  end
  assign i_ram_data = (RL == 2) ? st2 : st1;

  function automatic int lane_of(input int k);
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
    return 3 - k;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      int   er;
      if (!(i_req_valid && o_req_ready)) begin
        chk("ram_en_idle", {31'd0, o_ram_en}, 32'd0);
        chk("ram_we_idle", {28'd0, o_ram_we}, 32'd0);
      end
      if (q.size() > 0 && cyc > q[0].acc) begin
        e  = q[0];
        er = e.acc + (e.is_load ? RL + 1 : 1);
        chk("busy_ready", {31'd0, o_req_ready}, 32'd0);
        if (cyc < er) begin
          chk("wait_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
          chk("wait_rea", {31'd0, o_ram_rea}, 32'd1);
        end else begin
          chk("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
          chk("rsp_rdata", o_rsp_rdata, e.rdata);
          chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
          chk("rsp_rea", {31'd0, o_ram_rea}, 32'd0);
          void'(q.pop_front());
        end
      end else begin
        chk("no_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("no_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("no_rsp_err", {31'd0, o_rsp_err}, 32'd0);
      end
    end
  end

  // Issue one request; called just after a rising edge, returns just after one.
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold);
    bit          legal;
    int          nb;
    int          ba;
    int          waited;
    logic [3:0]  want_we;
    logic [31:0] want_data;
    logic [31:0] val;
    logic [31:0] mask;
    exp_t        e;
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_addr     = a;
    i_req_wdata    = wd;
    waited = 0;
    forever begin
      @(negedge clk);
      if (o_req_ready) break;
      waited++;
      if (waited > 20) begin
        chk("ready_timeout", {31'd0, o_req_ready}, 32'd1);
        break;
      end
    end
    last_acc = cyc;
    legal = (size == 2'd0) || (size == 2'd1 && a[0] == 1'b0) || (size == 2'd2 && a[1:0] == 2'd0);
    nb    = 1 << size;
    ba    = int'(a[AW+1:0]);
    want_we = 4'd0;
    if (legal && we)
      for (int i = 0; i < nb; i++) want_we[lane_of((ba + i) % 4)] = 1'b1;
    case (size)
      2'd0:    want_data = {4{wd[7:0]}};
      2'd1:    want_data = {2{wd[15:0]}};
      default: want_data = wd;
    endcase
    chk("c0_ram_en", {31'd0, o_ram_en}, {31'd0, legal});
    chk("c0_ram_we", {28'd0, o_ram_we}, {28'd0, want_we});
    if (legal) chk("c0_ram_addr", {21'd0, o_ram_addr}, {21'd0, a[AW+1:2]});
    if (legal && we) chk("c0_ram_data", o_ram_data, want_data);
    val = 32'd0;
    if (legal) begin
      for (int i = 0; i < nb; i++) begin
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
        int sh = 8 * (nb - 1 - i);
`else
        int sh = 8 * i;
`endif
        if (we) ref_mem[(ba + i) % NBYTES] = wd[sh +: 8];
        else    val = val | (32'(ref_mem[(ba + i) % NBYTES]) << sh);
      end
      if (!we && nb < 4) begin
        mask = (32'd1 << (8 * nb)) - 32'd1;
        if (!uns && val[8*nb-1]) val = val | ~mask;
      end
    end
    e.acc     = cyc;
    e.is_load = legal && !we;
    e.rdata   = (legal && !we) ? val : 32'd0;
    e.err     = !legal;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) i_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 20) begin
      idle(1);
      t++;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          d;
    for (int w = 0; w < (1 << AW); w++) begin
      r = $urandom;
      for (int k = 0; k < 4; k++) begin
        ref_mem[4*w + k] = r[8*k +: 8];
        bram[w][8*lane_of(k) +: 8] = r[8*k +: 8];
      end
    end
    i_reset_n = 1'b0;
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0;
    i_req_unsigned = 1'b0; i_req_addr = 32'd0; i_req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_ram_en", {31'd0, o_ram_en}, 32'd0);
    chk("rst_ram_rea", {31'd0, o_ram_rea}, 32'd0);
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // Directed cases
    issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
    issue(1, 2'd0, 0, 32'h13, 32'h000000A5, 0);
    issue(0, 2'd0, 0, 32'h13, 32'h0, 0);
    issue(0, 2'd0, 1, 32'h13, 32'h0, 0);
    issue(1, 2'd2, 0, 32'h10, 32'h80011234, 0);
    issue(0, 2'd1, 0, 32'h12, 32'h0, 0);
    issue(0, 2'd1, 1, 32'h12, 32'h0, 0);
    issue(0, 2'd2, 0, 32'h06, 32'h0, 0);
    issue(1, 2'd3, 0, 32'h00, 32'h12345678, 0);
    issue(0, 2'd3, 1, 32'h20, 32'h0, 0);
    issue(1, 2'd1, 0, 32'h21, 32'hFFFF, 0);
    issue(0, 2'd2, 0, 32'hFFFF_E010, 32'h0, 0);
    drain();

    // Back-to-back loads with valid held high
    issue(0, 2'd2, 0, 32'h20, 32'h0, 1);
    d = last_acc;
    issue(0, 2'd2, 0, 32'h24, 32'h0, 0);
    chk("b2b_accept_gap", last_acc - d, RL + 2);
    drain();

    // Reset in the middle of a load
    issue(0, 2'd2, 0, 32'h30, 32'h0, 0);
    mon_en = 1'b0;
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("midrst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("midrst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    chk("midrst_ram_en", {31'd0, o_ram_en}, 32'd0);
    chk("midrst_ram_we", {28'd0, o_ram_we}, 32'd0);
    chk("midrst_ram_rea", {31'd0, o_ram_rea}, 32'd0);
    chk("midrst_ram_data", o_ram_data, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
    idle(5);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          p;
      p  = $urandom_range(0, 9);
      sz = (p < 3) ? 2'd0 : (p < 6) ? 2'd1 : (p < 9) ? 2'd2 : 2'd3;
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_E000);
      issue(bit'($urandom_range(0, 1)), sz, bit'($urandom_range(0, 1)), a, $urandom, 0);
      idle($urandom_range(0, 2));
    end
    drain();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator that sits between the MIPS pipeline's memory stage and one port of the byte-enabled dual-port data BRAM.
- Accepts one LB/LBU/LH/LHU/LW/SB/SH/SW request at a time.
- Generates the word address, byte write enables and lane-replicated store data.
- Waits out the BRAM read latency, then returns aligned, sign- or zero-extended load data.
- Flags misaligned and invalid-size requests without touching memory.

Parameters:
- RAM_ADDR_WIDTH, 11, width of the BRAM word address (depth 2048).
- READ_LATENCY, 2, BRAM read latency in cycles: 1 for the low-latency BRAM build, 2 for the output-registered build. Only 1 and 2 are legal.

Ports:
- i_clock  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  unit can accept a request this cycle
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 invalid
- i_req_unsigned  in  1  zero-extend loads (LBU/LHU)
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  request was misaligned or invalid size; valid with o_rsp_valid
- o_ram_en  out  1  BRAM port enable
- o_ram_we  out  4  BRAM byte write enables, lane k = bits [8k+7:8k]
- o_ram_addr  out  RAM_ADDR_WIDTH  BRAM word address
- o_ram_data  out  32  BRAM write data
- o_ram_rea  out  1  BRAM output register enable
- i_ram_data  in  32  BRAM read data

Behaviour:
- Interface: one clock, i_clock; reset is asynchronous and active-low on i_reset_n.
- Reset values: all outputs 0 except o_req_ready; state IDLE. Assertion mid-operation drops any pending transaction immediately; no response is produced for it.
- States:
  - IDLE: o_req_ready=1; a request is accepted on i_req_valid & o_req_ready (the accept cycle, C0).
  - WAIT: holds for READ_LATENCY cycles.
  - RESP: o_rsp_valid=1 for exactly one cycle, then return to IDLE.
- Transitions:
  - Store accepted: IDLE→RESP.
  - Load accepted: IDLE→WAIT→RESP.
  - Error (misaligned or invalid size): IDLE→RESP.
- Latency:
  - Store and error response in C1.
  - Load response in C(READ_LATENCY+1).
  - o_req_ready is low from C1 until IDLE is re-entered. Throughput is one store per 2 cycles and one load per READ_LATENCY+2 cycles.
- RAM drive in C0 (combinational from the accepted request):
  - o_ram_en=1 for legal requests only.
  - o_ram_addr = i_req_addr[RAM_ADDR_WIDTH+1:2]; upper address bits are ignored (wrap).
- Byte lanes, little-endian (byte offset k ↔ lane k), off = i_req_addr[1:0]:
  - SB: we = 0001<<off, o_ram_data = wdata[7:0] replicated ×4.
  - SH: we = 0011<<off, o_ram_data = wdata[15:0] replicated ×2.
  - SW: we = 1111, o_ram_data = wdata.
  - Loads: we = 0000.
- Outside C0: o_ram_en=0, o_ram_we=0. With i_req_valid low in IDLE, the RAM port stays idle.
- o_ram_rea = 1 throughout WAIT.
- Load capture:
  - Offset, size and unsigned are latched at C0.
  - i_ram_data is registered in the final WAIT cycle.
  - The byte at lane off, or the half at lanes off..off+1, is sign-extended, or zero-extended when unsigned is set.
  - o_rsp_rdata is held 0 outside RESP.
- Errors:
  - Half with addr[0]=1, word with addr[1:0]≠0, and size 11 are errors.
  - Errors do no RAM access and return o_rsp_err=1, rdata=0.

Optional Feature:
- Macro: MEM_ACCESS_BIG_ENDIAN_EN.
- Defined: big-endian lane mapping, byte offset k ↔ lane 3-k. SB off0 → we=1000; SH off0 → we=1100. Load extraction mirrors this mapping.
- Undefined: little-endian mapping as in Behaviour.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF → C0: ram_en=1, we=1111, ram_addr=4, ram_data=0xDEADBEEF; C1: rsp_valid=1, err=0, rdata=0.
- SB addr 0x13 wdata 0x000000A5 → we=1000, ram_data=0xA5A5A5A5. Then LB addr 0x13 with i_ram_data=0xA5000000 (READ_LATENCY=2) → C3: rdata=0xFFFFFFA5; LBU gives 0x000000A5.
- LH addr 0x12, i_ram_data=0x80011234 → rdata=0xFFFF8001; LHU → 0x00008001; rea=1 in C1–C2.
- LW addr 0x06, and any request with size=11 → ram_en=0 in C0; C1: rsp_valid=1, err=1, rdata=0.
- Two LWs with i_req_valid held high → ready low C1–C3, second accept in C4 (READ_LATENCY=2) or C3 (READ_LATENCY=1).
- i_reset_n driven low during WAIT → all outputs 0 at once; no rsp_valid after release; ready=1 in the first cycle after release.
